// File: rtl/core_muldiv_seq_pkg.sv
// core_muldiv_seq_pkg
//   Shared constants and types for the iterative M-extension unit.
//   - OPERAND_WIDTH / ALU_CTRL_WIDTH: default datapath and op-code widths.
//   - OP_*: M-extension op codes (MSB=1), shared with the ALU decoder.
//   - state_t: sequencer state encoding.
//   - op_info_t / decode_op(): op code -> datapath control flags.
package core_muldiv_seq_pkg;

  localparam int OPERAND_WIDTH  = 64;
  localparam int ALU_CTRL_WIDTH = 5;

  localparam logic [ALU_CTRL_WIDTH-1:0] OP_MUL    = 5'b10000;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_MULH   = 5'b10001;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_MULHSU = 5'b10011;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_MULHU  = 5'b10010;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_DIV    = 5'b10110;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_DIVU   = 5'b10100;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_REM    = 5'b10101;
  localparam logic [ALU_CTRL_WIDTH-1:0] OP_REMU   = 5'b10111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_CALC,
    ST_FIXUP,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic legal;       // recognised M-extension op
    logic is_div;      // divide/remainder family
    logic is_rem;      // return remainder instead of quotient
    logic high;        // multiply: return upper half of product
    logic rs1_signed;
    logic rs2_signed;
  } op_info_t;

  // Any code outside the eight M-extension encodings (including every
  // MSB=0 code) decodes as illegal and produces a zero result.
  function automatic op_info_t decode_op(input logic [ALU_CTRL_WIDTH-1:0] op);
    op_info_t info;
    info = '0;
    case (op)
      OP_MUL:    info = '{legal: 1'b1, is_div: 1'b0, is_rem: 1'b0, high: 1'b0, rs1_signed: 1'b1, rs2_signed: 1'b1};
      OP_MULH:   info = '{legal: 1'b1, is_div: 1'b0, is_rem: 1'b0, high: 1'b1, rs1_signed: 1'b1, rs2_signed: 1'b1};
      OP_MULHSU: info = '{legal: 1'b1, is_div: 1'b0, is_rem: 1'b0, high: 1'b1, rs1_signed: 1'b1, rs2_signed: 1'b0};
      OP_MULHU:  info = '{legal: 1'b1, is_div: 1'b0, is_rem: 1'b0, high: 1'b1, rs1_signed: 1'b0, rs2_signed: 1'b0};
      OP_DIV:    info = '{legal: 1'b1, is_div: 1'b1, is_rem: 1'b0, high: 1'b0, rs1_signed: 1'b1, rs2_signed: 1'b1};
      OP_DIVU:   info = '{legal: 1'b1, is_div: 1'b1, is_rem: 1'b0, high: 1'b0, rs1_signed: 1'b0, rs2_signed: 1'b0};
      OP_REM:    info = '{legal: 1'b1, is_div: 1'b1, is_rem: 1'b1, high: 1'b0, rs1_signed: 1'b1, rs2_signed: 1'b1};
      OP_REMU:   info = '{legal: 1'b1, is_div: 1'b1, is_rem: 1'b1, high: 1'b0, rs1_signed: 1'b0, rs2_signed: 1'b0};
      default:   info = '0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/core_muldiv_step.sv
// core_muldiv_step
//   One combinational iteration on the 2*XLEN accumulator.
//   - acc      in   2*XLEN  current accumulator {hi, lo}
//   - operand  in   XLEN    multiplicand (multiply) or divisor (divide)
//   - is_div   in   1       select restoring-divide step instead of shift-add
//   - acc_next out  2*XLEN  accumulator after this iteration
//   Multiply: lo holds the multiplier; add operand to hi when lo[0]=1, then
//   shift the whole {carry, hi, lo} right one place.
//   Divide: lo holds the dividend; shift {hi, lo} left one place, try to
//   subtract the divisor from hi and shift the success bit into lo[0].
module core_muldiv_step #(
  parameter int XLEN = 64
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [XLEN-1:0]   operand,
  input  logic              is_div,
  output logic [2*XLEN-1:0] acc_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted_hi;
  logic [XLEN:0] diff;

  always_comb begin
    sum        = {1'b0, acc[2*XLEN-1:XLEN]} + ({1'b0, operand} & {(XLEN+1){acc[0]}});
    // hi after the left shift needs one extra bit: it can reach 2*divisor-1.
    shifted_hi = acc[2*XLEN-1:XLEN-1];
    diff       = shifted_hi - {1'b0, operand};
    if (is_div) begin
      // diff MSB set means the trial subtraction borrowed: keep shifted value.
      if (!diff[XLEN]) begin
        acc_next = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      end else begin
        acc_next = {shifted_hi[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/core_muldiv_seq.sv
// core_muldiv_seq
//   Iterative RV64 M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//   with valid/ready on both sides. Sign handling is done around an unsigned
//   magnitude core: magnitudes on accept, sign fix-up after XLEN iterations.
//   Ports:
//   - clk, rst_n        clock (rising edge), asynchronous active-low reset
//   - valid_i/ready_o   request handshake; ready_o high only in IDLE
//   - op_i              op code (M-extension codes have MSB=1)
//   - oprd1, oprd2      rs1 / rs2 operands
//   - flush_i           abort the in-flight operation (ignored in IDLE)
//   - valid_o/ready_i   result handshake; result_o held until taken
//   - result_o          registered result
//   - busy_o            sequencer not in IDLE
//   Build option: MULDIV_EARLY_OUT_EN -- when defined, divide by zero and
//   multiply by zero complete straight from accept (result in the next
//   cycle); otherwise every legal op takes the full iterative latency.
module core_muldiv_seq
  import core_muldiv_seq_pkg::*;
#(
  parameter int XLEN  = OPERAND_WIDTH,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [ALU_CTRL_WIDTH-1:0] op_i,
  input  logic [XLEN-1:0]           oprd1,
  input  logic [XLEN-1:0]           oprd2,
  input  logic                      flush_i,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic [XLEN-1:0]           result_o,
  output logic                      busy_o
);

  state_t state_reg, state_next;

  // Latched request
  logic              is_div_reg;
  logic              is_rem_reg;
  logic              high_reg;
  logic              neg_q_reg;     // operand signs differ: negate product/quotient
  logic              neg_r_reg;     // dividend negative: negate remainder
  logic [XLEN-1:0]   rs1_reg;       // original rs1, returned by REM on divide by zero
  logic [XLEN-1:0]   mag1_reg;
  logic [XLEN-1:0]   mag2_reg;

  // Iteration state
  logic [2*XLEN-1:0] acc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              div_zero_reg;
  logic [XLEN-1:0]   result_reg;

  // Request-side decode
  op_info_t          in_info;
  logic              in_sign1;
  logic              in_sign2;
  logic [XLEN-1:0]   in_mag1;
  logic [XLEN-1:0]   in_mag2;
  logic              early_done;
  logic [XLEN-1:0]   early_result;

  // Datapath
  logic [2*XLEN-1:0] acc_step;
  logic [2*XLEN-1:0] product;
  logic [XLEN-1:0]   quotient;
  logic [XLEN-1:0]   remainder;
  logic [XLEN-1:0]   fix_result;

  always_comb begin
    in_info  = decode_op(op_i);
    in_sign1 = in_info.rs1_signed & oprd1[XLEN-1];
    in_sign2 = in_info.rs2_signed & oprd2[XLEN-1];
    // -(-2^(XLEN-1)) wraps back to 2^(XLEN-1), which is the correct
    // unsigned magnitude.
    in_mag1  = in_sign1 ? -oprd1 : oprd1;
    in_mag2  = in_sign2 ? -oprd2 : oprd2;
  end

`ifdef MULDIV_EARLY_OUT_EN
  always_comb begin
    early_done   = 1'b0;
    early_result = '0;
    if (in_info.legal) begin
      if (in_info.is_div) begin
        early_done   = (oprd2 == '0);
        early_result = in_info.is_rem ? oprd1 : {XLEN{1'b1}};
      end else begin
        early_done   = (oprd1 == '0) || (oprd2 == '0);
        early_result = '0;
      end
    end
  end
`else
  always_comb begin
    early_done   = 1'b0;
    early_result = '0;
  end
`endif

  core_muldiv_step #(
    .XLEN(XLEN)
  ) u_step (
    .acc      (acc_reg),
    .operand  (is_div_reg ? mag2_reg : mag1_reg),
    .is_div   (is_div_reg),
    .acc_next (acc_step)
  );

  // Sign fix-up and result selection from the finished accumulator.
  always_comb begin
    product   = neg_q_reg ? -acc_reg : acc_reg;
    quotient  = neg_q_reg ? -acc_reg[XLEN-1:0] : acc_reg[XLEN-1:0];
    remainder = neg_r_reg ? -acc_reg[2*XLEN-1:XLEN] : acc_reg[2*XLEN-1:XLEN];
    if (div_zero_reg) begin
      quotient  = {XLEN{1'b1}};
      remainder = rs1_reg;
    end
    if (is_div_reg) begin
      fix_result = is_rem_reg ? remainder : quotient;
    end else begin
      fix_result = high_reg ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (valid_i) begin
          state_next = (!in_info.legal || early_done) ? ST_DONE : ST_PREP;
        end
      end
      ST_PREP:  state_next = ST_CALC;
      ST_CALC: begin
        if (cnt_reg == CNT_W'(1)) begin
          state_next = ST_FIXUP;
        end
      end
      ST_FIXUP: state_next = ST_DONE;
      ST_DONE: begin
        if (ready_i) begin
          state_next = ST_IDLE;
        end
      end
      default:  state_next = ST_IDLE;
    endcase
    // Flush outranks everything, including a result being taken.
    if (flush_i && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div_reg   <= 1'b0;
      is_rem_reg   <= 1'b0;
      high_reg     <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      rs1_reg      <= '0;
      mag1_reg     <= '0;
      mag2_reg     <= '0;
      acc_reg      <= '0;
      cnt_reg      <= '0;
      div_zero_reg <= 1'b0;
      result_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (valid_i) begin
            is_div_reg <= in_info.is_div;
            is_rem_reg <= in_info.is_rem;
            high_reg   <= in_info.high;
            neg_q_reg  <= in_sign1 ^ in_sign2;
            neg_r_reg  <= in_sign1;
            rs1_reg    <= oprd1;
            mag1_reg   <= in_mag1;
            mag2_reg   <= in_mag2;
            if (!in_info.legal) begin
              result_reg <= '0;
            end else if (early_done) begin
              result_reg <= early_result;
            end
          end
        end
        ST_PREP: begin
          // Divide iterates on the dividend, multiply on the multiplier;
          // the other magnitude is fed to the step as its operand.
          acc_reg      <= is_div_reg ? {{XLEN{1'b0}}, mag1_reg} : {{XLEN{1'b0}}, mag2_reg};
          cnt_reg      <= CNT_W'(XLEN);
          div_zero_reg <= (mag2_reg == '0);
        end
        ST_CALC: begin
          acc_reg <= acc_step;
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
        ST_FIXUP: begin
          if (!flush_i) begin
            result_reg <= fix_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign ready_o  = (state_reg == ST_IDLE);
  assign busy_o   = (state_reg != ST_IDLE);
  assign valid_o  = (state_reg == ST_DONE);
  assign result_o = result_reg;

endmodule

// File: tb/tb_core_muldiv_seq.sv
// tb_core_muldiv_seq
//   Self-checking bench for core_muldiv_seq (default build). Expected results
//   are pushed to a queue when a request is accepted and popped when the
//   result handshake completes.
module tb_core_muldiv_seq;
  import core_muldiv_seq_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        ready_o;
  logic [4:0]  op_i;
  logic [63:0] oprd1;
  logic [63:0] oprd2;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic [63:0] result_o;
  logic        busy_o;

  int vectors     = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];

  core_muldiv_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .op_i     (op_i),
    .oprd1    (oprd1),
    .oprd2    (oprd2),
    .flush_i  (flush_i),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Independent reference model built on wide arithmetic.
  function automatic logic [63:0] model(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0]       sa, sb, ua, ub, p;
    logic signed [63:0] da, db;
    logic [63:0]        r;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    ua = {64'd0, a};
    ub = {64'd0, b};
    da = a;
    db = b;
    r  = '0;
    case (op)
      OP_MUL:    begin p = ua * ub; r = p[63:0];   end
      OP_MULH:   begin p = sa * sb; r = p[127:64]; end
      OP_MULHSU: begin p = sa * ub; r = p[127:64]; end
      OP_MULHU:  begin p = ua * ub; r = p[127:64]; end
      OP_DIV: begin
        if (b == 64'd0) r = '1;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
        else r = da / db;
      end
      OP_DIVU:   r = (b == 64'd0) ? '1 : a / b;
      OP_REM: begin
        if (b == 64'd0) r = a;
        else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
        else r = da % db;
      end
      OP_REMU:   r = (b == 64'd0) ? a : a % b;
      default:   r = '0;
    endcase
    return r;
  endfunction

  // Present one request from IDLE (called #1 after a rising edge).
  task automatic issue(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input bit push);
    vectors++;
    if (ready_o !== 1'b1) begin
      $display("FAIL ready_before_issue: ready_o=%b required 1", ready_o);
      miscompares++;
    end
    op_i = op; oprd1 = a; oprd2 = b; valid_i = 1'b1;
    if (push) exp_q.push_back(exp);
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Wait for valid_o, compare against the scoreboard, take the result.
  task automatic collect(input string name);
    int n;
    logic [63:0] exp;
    n = 0;
    while (valid_o !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
    vectors++;
    if (valid_o !== 1'b1) begin
      $display("FAIL %s: timeout waiting for valid_o, required %h", name, exp);
      miscompares++;
      return;
    end
    if (result_o !== exp) begin
      $display("FAIL %s: result_o=%h required %h", name, result_o, exp);
      miscompares++;
    end else begin
      $display("ok   %s: result_o=%h", name, result_o);
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    vectors++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      $display("FAIL %s_handshake: ready_o=%b valid_o=%b required 1/0", name, ready_o, valid_o);
      miscompares++;
    end
  endtask

  task automatic run(input string name, input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                     input logic [63:0] exp);
    issue(op, a, b, exp, 1'b1);
    collect(name);
  endtask

  task automatic check_reset_outputs(input string name);
    vectors++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 64'd0) begin
      $display("FAIL %s: ready=%b valid=%b busy=%b result=%h required 1/0/0/0",
               name, ready_o, valid_o, busy_o, result_o);
      miscompares++;
    end else begin
      $display("ok   %s: reset outputs", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul_stall();
    logic [63:0] exp;
    exp = 64'hFFFF_FFFF_FFFF_FFEB;
    issue(OP_MUL, 64'd7, -64'sd3, exp, 1'b1);
    // Accept cycle counts as cycle k+1 of 67: valid_o appears 66 edges later.
    repeat (65) begin @(posedge clk); #1; end
    vectors++;
    if (valid_o !== 1'b0) begin
      $display("FAIL mul_latency_early: valid_o=%b required 0 at edge 65", valid_o);
      miscompares++;
    end
    @(posedge clk); #1;
    vectors++;
    if (valid_o !== 1'b1) begin
      $display("FAIL mul_latency: valid_o=%b required 1 at edge 66", valid_o);
      miscompares++;
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (valid_o !== 1'b1 || result_o !== exp) begin
        $display("FAIL mul_stall_%0d: valid_o=%b result_o=%h required 1/%h", i, valid_o, result_o, exp);
        miscompares++;
      end
    end
    collect("mul_7x-3");
  endtask

  task automatic test_mul_high();
    run("mulh_-1x-1",  OP_MULH,   '1, '1,    64'd0);
    run("mulhu_max_x2", OP_MULHU, '1, 64'd2, 64'd1);
    run("mulhsu_-1x2", OP_MULHSU, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  task automatic test_div_rem();
    run("div_-7/2",    OP_DIV,  -64'sd7, 64'd2, -64'sd3);
    run("rem_-7/2",    OP_REM,  -64'sd7, 64'd2, -64'sd1);
    run("divu_100/7",  OP_DIVU, 64'd100, 64'd7, 64'd14);
    run("remu_100/7",  OP_REMU, 64'd100, 64'd7, 64'd2);
  endtask

  task automatic test_div_corner();
    run("div_5/0",     OP_DIV, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
    run("rem_5/0",     OP_REM, 64'd5, 64'd0, 64'd5);
    run("div_ovf",     OP_DIV, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000);
    run("rem_ovf",     OP_REM, 64'h8000_0000_0000_0000, '1, 64'd0);
    run("illegal_op",  5'b00011, 64'd9, 64'd9, 64'd0);
  endtask

  task automatic test_random();
    logic [4:0]  ops[8];
    logic [4:0]  op;
    logic [63:0] a, b;
    ops = '{OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    for (int i = 0; i < 12; i++) begin
      op = ops[i % 8];
      a  = {$urandom, $urandom};
      b  = (i % 3 == 0) ? {{48{a[5]}}, 16'($urandom)} : {$urandom, $urandom};
      run($sformatf("rand_%0d", i), op, a, b, model(op, a, b));
    end
  endtask

  task automatic test_flush();
    issue(OP_MUL, 64'd123, 64'd456, 64'd0, 1'b0);
    repeat (10) begin @(posedge clk); #1; end   // now in CALC cycle 10
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    vectors++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1 || busy_o !== 1'b0) begin
      $display("FAIL flush: valid_o=%b ready_o=%b busy_o=%b required 0/1/0", valid_o, ready_o, busy_o);
      miscompares++;
    end else begin
      $display("ok   flush: unit idle");
    end
    repeat (70) begin
      @(posedge clk); #1;
      if (valid_o !== 1'b0) break;
    end
    vectors++;
    if (valid_o !== 1'b0) begin
      $display("FAIL flush_no_valid: valid_o=%b required 0", valid_o);
      miscompares++;
    end
    run("mul_3x4_after_flush", OP_MUL, 64'd3, 64'd4, 64'd12);
  endtask

  task automatic test_reset_mid();
    issue(OP_DIVU, 64'd1000, 64'd3, 64'd0, 1'b0);
    repeat (20) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid_calc");
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    issue(OP_MULHU, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210,
          model(OP_MULHU, 64'h1234_5678_9ABC_DEF0, 64'hFEDC_BA98_7654_3210), 1'b1);
    collect("b2b_mulhu");
    issue(OP_DIV, -64'sd1000, 64'd7, -64'sd142, 1'b1);
    collect("b2b_div");
    issue(OP_REMU, '1, 64'd10, 64'd5, 1'b1);
    collect("b2b_remu");
  endtask

  initial begin
    rst_n   = 1'b0;
    valid_i = 1'b0;
    op_i    = '0;
    oprd1   = '0;
    oprd2   = '0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    test_reset();
    test_mul_stall();
    test_mul_high();
    test_div_rem();
    test_div_corner();
    test_random();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
